// File: rtl/core_pkg.sv
// core package: shared types for the branch predictor slice.
//   bool_t               single-bit flag
//   peval_width          number of parallel prediction lookup ports
//   branch_pred_req_t    lookup request (base_pc)
//   branch_pred_rsp_t    lookup response (branch_taken, eval_alt)
//   branch_pred_fb_t     resolved-branch feedback (valid, base_pc, targ_pc, branch_taken)
//   bp_ctr_e             2-bit saturating counter encoding, BP_CTR_INIT reset value
//   bp_state_e           predictor FSM states
package core;

  typedef logic bool_t;

  localparam int unsigned peval_width       = 2;
  localparam int unsigned pc_width          = 32;
  localparam int unsigned bp_idx_width_dflt = 6;

  typedef logic [pc_width-1:0] pc_t;

  typedef struct packed {
    pc_t base_pc;
  } branch_pred_req_t;

  typedef struct packed {
    bool_t branch_taken;
    bool_t eval_alt;
  } branch_pred_rsp_t;

  typedef struct packed {
    bool_t valid;
    pc_t   base_pc;
    pc_t   targ_pc;
    bool_t branch_taken;
  } branch_pred_fb_t;

  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bp_ctr_e;

  localparam bp_ctr_e BP_CTR_INIT = BP_CTR_WNT;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_e;

  // Weak states are the ones where the prediction may flip on the next update.
  function automatic bool_t bp_ctr_weak(input bp_ctr_e c);
    return (c == BP_CTR_WNT) || (c == BP_CTR_WT);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: combinational next value of a 2-bit saturating counter.
//   ctr_i  current counter value
//   inc_i  1 = step toward strong-taken, 0 = step toward strong-not-taken
//   ctr_o  next counter value, saturating at BP_CTR_ST / BP_CTR_SNT
module bp_sat_counter
  import core::*;
(
  input  bp_ctr_e ctr_i,
  input  logic    inc_i,
  output bp_ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      BP_CTR_SNT: ctr_o = inc_i ? BP_CTR_WNT : BP_CTR_SNT;
      BP_CTR_WNT: ctr_o = inc_i ? BP_CTR_WT  : BP_CTR_SNT;
      BP_CTR_WT:  ctr_o = inc_i ? BP_CTR_ST  : BP_CTR_WNT;
      BP_CTR_ST:  ctr_o = inc_i ? BP_CTR_ST  : BP_CTR_WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal table of 2-bit saturating counters.
// After reset the table is walked one entry per cycle (INIT) writing weak-not-taken,
// then predictions are served (RUN) and trained by resolved-branch feedback.
//   clk              system clock, all state on rising edge
//   rst              synchronous active-high reset
//   branch_pred_req  per-port lookup requests (base_pc)
//   branch_pred_rsp  per-port combinational predictions (branch_taken, eval_alt)
//   branch_pred_fb   resolved-branch feedback (valid, base_pc, targ_pc, branch_taken)
//   bp_ready         table initialised, predictions meaningful
// Optional feature macro: BRANCH_PRED_GSHARE_EN -- XORs a global taken/not-taken
// history register into both the lookup and the update index.
module branch_predictor
  import core::*;
#(
  parameter int unsigned bp_idx_width = bp_idx_width_dflt
) (
  input  logic             clk,
  input  bool_t            rst,
  input  branch_pred_req_t branch_pred_req [peval_width],
  output branch_pred_rsp_t branch_pred_rsp [peval_width],
  input  branch_pred_fb_t  branch_pred_fb,
  output bool_t            bp_ready
);

  localparam int unsigned Depth = 2 ** bp_idx_width;

  typedef logic [bp_idx_width-1:0] idx_t;

  bp_ctr_e   table_q [Depth];
  bp_state_e state_q, state_d;
  idx_t      init_idx_q, init_idx_d;
  idx_t      hist_cur;

  logic      tbl_we;
  idx_t      tbl_widx;
  bp_ctr_e   tbl_wdata;

  idx_t      fb_idx;
  bp_ctr_e   fb_ctr_cur;
  bp_ctr_e   fb_ctr_nxt;

`ifdef BRANCH_PRED_GSHARE_EN
  idx_t hist_q, hist_d;
  assign hist_cur = hist_q;
`else
  assign hist_cur = '0;
`endif

  assign bp_ready = (state_q == BP_RUN) && !rst;

  // Feedback path: update index uses the history before this cycle's shift.
  assign fb_idx     = branch_pred_fb.base_pc[bp_idx_width+1:2] ^ hist_cur;
  assign fb_ctr_cur = table_q[fb_idx];

  bp_sat_counter u_sat (
    .ctr_i (fb_ctr_cur),
    .inc_i (branch_pred_fb.branch_taken),
    .ctr_o (fb_ctr_nxt)
  );

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    tbl_we     = 1'b0;
    tbl_widx   = init_idx_q;
    tbl_wdata  = BP_CTR_INIT;
`ifdef BRANCH_PRED_GSHARE_EN
    hist_d     = hist_q;
`endif
    unique case (state_q)
      BP_INIT: begin
        tbl_we     = 1'b1;
        init_idx_d = init_idx_q + idx_t'(1);
`ifdef BRANCH_PRED_GSHARE_EN
        hist_d     = '0;
`endif
        if (init_idx_q == '1) begin
          state_d = BP_RUN;
        end
      end
      BP_RUN: begin
        if (branch_pred_fb.valid) begin
          tbl_we    = 1'b1;
          tbl_widx  = fb_idx;
          tbl_wdata = fb_ctr_nxt;
`ifdef BRANCH_PRED_GSHARE_EN
          hist_d    = {hist_q[bp_idx_width-2:0], branch_pred_fb.branch_taken};
`endif
        end
      end
    endcase
    // Reset wins over any table write scheduled by the current state.
    if (rst) begin
      tbl_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
`ifdef BRANCH_PRED_GSHARE_EN
      hist_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
`ifdef BRANCH_PRED_GSHARE_EN
      hist_q     <= hist_d;
`endif
    end
  end

  // Table carries no reset: the INIT walk defines every entry before bp_ready.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[tbl_widx] <= tbl_wdata;
    end
  end

  // Lookups read registered state only, so same-cycle feedback is not bypassed.
  for (genvar p = 0; p < int'(peval_width); p++) begin : g_lookup
    idx_t             rd_idx;
    bp_ctr_e          rd_ctr;
    branch_pred_rsp_t rsp;
    logic             unused_req_bits;

    assign rd_idx           = branch_pred_req[p].base_pc[bp_idx_width+1:2] ^ hist_cur;
    assign rd_ctr           = table_q[rd_idx];
    assign rsp.branch_taken = bp_ready & rd_ctr[1];
    assign rsp.eval_alt     = bp_ready & bp_ctr_weak(rd_ctr);
    assign branch_pred_rsp[p] = rsp;
    assign unused_req_bits  = ^{branch_pred_req[p].base_pc[pc_width-1:bp_idx_width+2],
                                branch_pred_req[p].base_pc[1:0]};
  end

  logic unused_fb_bits;
  assign unused_fb_bits = ^{branch_pred_fb.targ_pc,
                            branch_pred_fb.base_pc[pc_width-1:bp_idx_width+2],
                            branch_pred_fb.base_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized bench for branch_predictor with a
// behavioural reference (counter array, init countdown, optional history).
module tb_branch_predictor;
  import core::*;

  localparam int DEPTH = 64;

  logic             clk;
  bool_t            rst;
  branch_pred_req_t req [peval_width];
  branch_pred_rsp_t rsp [peval_width];
  branch_pred_fb_t  fb;
  bool_t            ready;

  branch_predictor #(.bp_idx_width(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_pred_req (req),
    .branch_pred_rsp (rsp),
    .branch_pred_fb  (fb),
    .bp_ready        (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mctr [DEPTH];
  int init_rem = DEPTH;
  int hist = 0;
  logic last_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return !rst && (init_rem == 0);
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return ((pc / 4) % DEPTH) ^ hist;
  endfunction

  // {taken, eval_alt}
  function automatic logic [1:0] m_pred(input logic [31:0] pc);
    int c;
    if (!m_ready()) return 2'b00;
    c = mctr[m_idx(pc)];
    return {logic'(c >= 2), logic'(c == 1 || c == 2)};
  endfunction

  task automatic model_update();
    int ix;
    if (rst) begin
      init_rem = DEPTH;
      hist = 0;
    end else if (init_rem > 0) begin
      init_rem--;
      if (init_rem == 0) begin
        for (int i = 0; i < DEPTH; i++) mctr[i] = 1;
      end
    end else if (fb.valid) begin
      ix = m_idx(fb.base_pc);
      if (fb.branch_taken) begin
        if (mctr[ix] < 3) mctr[ix]++;
      end else begin
        if (mctr[ix] > 0) mctr[ix]--;
      end
`ifdef BRANCH_PRED_GSHARE_EN
      hist = (hist * 2 + (fb.branch_taken ? 1 : 0)) % DEPTH;
`endif
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model.
  task automatic tick();
    #4;
    last_ready = ready;
    check_eq("bp_ready", 32'(ready), 32'(m_ready()));
    for (int p = 0; p < int'(peval_width); p++) begin
      check_eq($sformatf("rsp%0d pc=%0h", p, req[p].base_pc),
               32'({rsp[p].branch_taken, rsp[p].eval_alt}), 32'(m_pred(req[p].base_pc)));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = $urandom;
    pc[7:6] = 2'b00;
    pc[5:2] = 4'($urandom_range(0, 15));
    return pc;
  endfunction

  task automatic rand_req();
    for (int p = 0; p < int'(peval_width); p++) req[p].base_pc = $urandom;
  endtask

  task automatic rand_fb(input int pct_valid);
    fb.valid        = ($urandom_range(0, 99) < pct_valid);
    fb.base_pc      = rand_pc();
    fb.targ_pc      = $urandom;
    fb.branch_taken = $urandom_range(0, 1);
  endtask

  task automatic fb_idle();
    fb = '0;
    fb.targ_pc = $urandom;
  endtask

  task automatic send_fb(input logic [31:0] pc, input logic taken);
    fb.valid        = 1'b1;
    fb.base_pc      = pc;
    fb.targ_pc      = $urandom;
    fb.branch_taken = taken;
    tick();
    fb_idle();
  endtask

  // Release reset and count not-ready cycles before bp_ready rises.
  task automatic count_init(input string tag, input int fb_pct);
    int cnt;
    cnt = 0;
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rand_req();
      rand_fb(fb_pct);
      tick();
      if (last_ready) break;
      cnt++;
    end
    fb_idle();
    check_eq(tag, 32'(cnt), 32'(DEPTH));
  endtask

  // Read every entry on port 0 (port 1 aliases the same index) against the model.
  task automatic scan_table();
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      pc[7:2] = 6'(i);
      req[0].base_pc = pc;
      pc[1:0] = 2'($urandom);
      pc[31:8] = 24'($urandom);
      req[1].base_pc = pc;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mctr[i] = 1;
    rst = 1'b1;
    fb_idle();
    rand_req();

    // Reset state, with feedback asserted while in reset
    rand_fb(100);
    tick();
    tick();
    count_init("init_cycles", 0);
    scan_table();

    // Same-cycle feedback and lookup at 0x200: no bypass, visible next cycle
    req[0].base_pc = 32'h200;
    req[1].base_pc = 32'h201;
    check_eq("pre_0x200", 32'({rsp[0].branch_taken, rsp[0].eval_alt}), 32'(m_pred(32'h200)));
    send_fb(32'h200, 1'b1);
    tick();

    // Two then three taken at 0x100, one not-taken at 0x104
    req[0].base_pc = 32'h100;
    req[1].base_pc = 32'h103;
    send_fb(32'h100, 1'b1);
    send_fb(32'h100, 1'b1);
    tick();
    send_fb(32'h100, 1'b1);
    tick();
    req[0].base_pc = 32'h104;
    send_fb(32'h104, 1'b0);
    tick();
    req[1].base_pc = 32'h100;
    tick();

    // Randomized traffic, port 1 frequently aliasing port 0
    for (int n = 0; n < 600; n++) begin
      req[0].base_pc = rand_pc();
      req[1].base_pc = ($urandom_range(0, 1) != 0) ? (req[0].base_pc ^ {24'($urandom), 6'b0, 2'($urandom)})
                                                   : rand_pc();
      rand_fb(60);
      tick();
    end
    fb_idle();

    // Reset mid-INIT at cycle 30 with feedback during INIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rand_req();
      rand_fb(100);
      tick();
    end
    rst = 1'b1;
    rand_fb(100);
    tick();
    count_init("reinit_cycles", 100);
    scan_table();

`ifdef BRANCH_PRED_GSHARE_EN
    // History 0 -> 1 after taken at 0x000; lookup 0x004 then folds back to entry 0
    req[0].base_pc = 32'h000;
    req[1].base_pc = 32'h004;
    send_fb(32'h000, 1'b1);
    check_eq("gshare_0x004", 32'(rsp[1].branch_taken), 32'(m_pred(32'h004) >> 1));
    tick();
`endif

    // Closing random burst
    for (int n = 0; n < 200; n++) begin
      rand_req();
      req[0].base_pc = rand_pc();
      rand_fb(50);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
